// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports (CPU MEM stage and
// debug/DMA) and the single data-memory port that the arbiter drives.
//
// Modports:
//   slave  - the arbiter side. It takes requests and mem_dataOut, and drives
//            responses, stalls and the memory controls.
//   master - the environment side. These are the requesters plus the memory.
//
// Parameters:
//   WORD_LEN - data and address width in bits.
interface dmem_arbiter_if #(
    parameter int WORD_LEN = 32
) ();

    // CPU MEM-stage port
    logic                cpu_req;
    logic                cpu_we;
    logic [WORD_LEN-1:0] cpu_addr;
    logic [WORD_LEN-1:0] cpu_wdata;
    logic [WORD_LEN-1:0] cpu_rdata;
    logic                cpu_ready;
    logic                cpu_err;
    logic                cpu_stall;

    // Debug/DMA port
    logic                dbg_req;
    logic                dbg_we;
    logic [WORD_LEN-1:0] dbg_addr;
    logic [WORD_LEN-1:0] dbg_wdata;
    logic [WORD_LEN-1:0] dbg_rdata;
    logic                dbg_ready;
    logic                dbg_err;
    logic                dbg_stall;

    // Shared data-memory port
    logic                mem_readEn;
    logic                mem_writeEn;
    logic [WORD_LEN-1:0] mem_address;
    logic [WORD_LEN-1:0] mem_dataIn;
    logic [WORD_LEN-1:0] mem_dataOut;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready, dbg_err, dbg_stall,
        output mem_readEn, mem_writeEn, mem_address, mem_dataIn,
        input  mem_dataOut
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready, dbg_err, dbg_stall,
        input  mem_readEn, mem_writeEn, mem_address, mem_dataIn,
        output mem_dataOut
    );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer in front of the data
// memory. The CPU MEM stage and a debug/DMA port share one memory port. Each
// access holds the memory for ACCESS_CYCLES cycles. The CPU is stalled while
// its request is outstanding. Misaligned requests are answered with err and
// do not touch the memory.
//
// Ports:
//   clk - clock; every state change happens on the rising edge.
//   rst - synchronous, active-high reset.
//   bus - dmem_arbiter_if.slave. It carries the cpu_* and dbg_* request and
//         response signals and the mem_* memory port.
//
// Parameters:
//   WORD_LEN      - data and address width (32).
//   ACCESS_CYCLES - cycles the memory port is held per access, 1..15 (2).
//
// Configuration macro:
//   DMEM_ARB_RR_EN - when defined, a tie goes to the port that was not served
//                    last (round-robin). When undefined, the CPU always wins
//                    a tie.
module dmem_arbiter #(
    parameter int WORD_LEN      = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       GRANT_CPU = 1'b0;
    localparam logic       GRANT_DBG = 1'b1;
    localparam logic [3:0] CNT_INIT  = 4'(ACCESS_CYCLES - 1);

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic                grant_r;
    logic                last_grant_r;
    logic                op_we_r;
    logic [WORD_LEN-1:0] op_addr_r;
    logic [WORD_LEN-1:0] op_wdata_r;
    logic [WORD_LEN-1:0] cpu_rdata_r;
    logic [WORD_LEN-1:0] dbg_rdata_r;
    logic                cpu_ready_r;
    logic                cpu_err_r;
    logic                dbg_ready_r;
    logic                dbg_err_r;
    logic                read_en_r;
    logic                write_en_r;

    logic                pick_dbg_s;
    logic                req_we_s;
    logic [WORD_LEN-1:0] req_addr_s;
    logic [WORD_LEN-1:0] req_wdata_s;

    // Pick the winner among the current requests and select its fields.
    always_comb begin
        pick_dbg_s = 1'b0;
        if (bus.cpu_req && bus.dbg_req) begin
`ifdef DMEM_ARB_RR_EN
            pick_dbg_s = (last_grant_r == GRANT_CPU);
`else
            pick_dbg_s = 1'b0;
`endif
        end else if (bus.dbg_req) begin
            pick_dbg_s = 1'b1;
        end else begin
            pick_dbg_s = 1'b0;
        end
        req_we_s    = pick_dbg_s ? bus.dbg_we    : bus.cpu_we;
        req_addr_s  = pick_dbg_s ? bus.dbg_addr  : bus.cpu_addr;
        req_wdata_s = pick_dbg_s ? bus.dbg_wdata : bus.cpu_wdata;
    end

    // Access sequencer: grant, memory hold, response pulse.
    // Memory enables are registered one cycle ahead, so each enable is high
    // in exactly the cycles that the state and count call for.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            grant_r      <= GRANT_CPU;
            last_grant_r <= GRANT_DBG;
            op_we_r      <= 1'b0;
            op_addr_r    <= {WORD_LEN{1'b0}};
            op_wdata_r   <= {WORD_LEN{1'b0}};
            cpu_rdata_r  <= {WORD_LEN{1'b0}};
            dbg_rdata_r  <= {WORD_LEN{1'b0}};
            cpu_ready_r  <= 1'b0;
            cpu_err_r    <= 1'b0;
            dbg_ready_r  <= 1'b0;
            dbg_err_r    <= 1'b0;
            read_en_r    <= 1'b0;
            write_en_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_ready_r  <= 1'b0;
                    cpu_err_r    <= 1'b0;
                    dbg_ready_r  <= 1'b0;
                    dbg_err_r    <= 1'b0;
                    read_en_r    <= 1'b0;
                    write_en_r   <= 1'b0;
                    last_grant_r <= last_grant_r;
                    if (bus.cpu_req || bus.dbg_req) begin
                        grant_r    <= pick_dbg_s;
                        op_we_r    <= req_we_s;
                        op_addr_r  <= req_addr_s;
                        op_wdata_r <= req_wdata_s;
                        if (req_addr_s[1:0] != 2'b00) begin
                            // Reject without a memory cycle.
                            state_r <= DONE;
                            cnt_r   <= 4'd0;
                            if (pick_dbg_s) begin
                                dbg_ready_r <= 1'b1;
                                dbg_err_r   <= 1'b1;
                            end else begin
                                cpu_ready_r <= 1'b1;
                                cpu_err_r   <= 1'b1;
                            end
                        end else begin
                            state_r    <= ACCESS;
                            cnt_r      <= CNT_INIT;
                            read_en_r  <= ~req_we_s;
                            // A single-cycle access writes in its only cycle.
                            write_en_r <= req_we_s & (CNT_INIT == 4'd0);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    last_grant_r <= last_grant_r;
                    if (cnt_r == 4'd0) begin
                        state_r    <= DONE;
                        read_en_r  <= 1'b0;
                        write_en_r <= 1'b0;
                        if (!op_we_r) begin
                            if (grant_r == GRANT_DBG) begin
                                dbg_rdata_r <= bus.mem_dataOut;
                            end else begin
                                cpu_rdata_r <= bus.mem_dataOut;
                            end
                        end
                        if (grant_r == GRANT_DBG) begin
                            dbg_ready_r <= 1'b1;
                            dbg_err_r   <= 1'b0;
                        end else begin
                            cpu_ready_r <= 1'b1;
                            cpu_err_r   <= 1'b0;
                        end
                    end else begin
                        cnt_r      <= cnt_r - 4'd1;
                        read_en_r  <= ~op_we_r;
                        // Write only in the final cycle: one write edge.
                        write_en_r <= op_we_r & (cnt_r == 4'd1);
                    end
                end
                DONE: begin
                    cpu_ready_r  <= 1'b0;
                    cpu_err_r    <= 1'b0;
                    dbg_ready_r  <= 1'b0;
                    dbg_err_r    <= 1'b0;
                    read_en_r    <= 1'b0;
                    write_en_r   <= 1'b0;
                    last_grant_r <= grant_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= 4'd0;
                    cpu_ready_r  <= 1'b0;
                    cpu_err_r    <= 1'b0;
                    dbg_ready_r  <= 1'b0;
                    dbg_err_r    <= 1'b0;
                    read_en_r    <= 1'b0;
                    write_en_r   <= 1'b0;
                    last_grant_r <= last_grant_r;
                end
            endcase
        end
    end

    // Enables are masked by rst so a reset cycle can never write memory.
    assign bus.mem_readEn  = read_en_r  & ~rst;
    assign bus.mem_writeEn = write_en_r & ~rst;
    assign bus.mem_address = op_addr_r;
    assign bus.mem_dataIn  = op_wdata_r;

    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.cpu_ready = cpu_ready_r;
    assign bus.cpu_err   = cpu_err_r;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ready_r;

    assign bus.dbg_rdata = dbg_rdata_r;
    assign bus.dbg_ready = dbg_ready_r;
    assign bus.dbg_err   = dbg_err_r;
    assign bus.dbg_stall = bus.dbg_req & ~dbg_ready_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter (ACCESS_CYCLES=2) with a
// small behavioural memory. Expected grant order follows DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   fail_cnt;
    int   write_cnt;
    int   read_cnt;

    logic [31:0] mem [0:1023];

    dmem_arbiter_if #(.WORD_LEN(32)) bus ();

    dmem_arbiter #(
        .WORD_LEN      (32),
        .ACCESS_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with a combinational read and a write on the rising edge.
    assign bus.mem_dataOut = mem[bus.mem_address[11:2]];

    // Memory write port and enable-cycle counters.
    always @(posedge clk) begin
        if (bus.mem_writeEn) begin
            mem[bus.mem_address[11:2]] <= bus.mem_dataIn;
            write_cnt = write_cnt + 1;
        end
        if (bus.mem_readEn) begin
            read_cnt = read_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] order;
    int         pulses;
    int         dbg_pulses;
    int         w0;
    int         r0;
    logic [3:0] exp_order;
    int         exp_dbg_pulses;

    initial begin
        pass_cnt = 0; total_cnt = 0; fail_cnt = 0; write_cnt = 0; read_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
        mem[32'h400 >> 2] = 32'hDEAD_BEEF;
        mem[32'h408 >> 2] = 32'h1111_1111;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("rst_dbg_ready", {31'd0, bus.dbg_ready}, 32'd0);
        check("rst_readEn",    {31'd0, bus.mem_readEn}, 32'd0);
        check("rst_writeEn",   {31'd0, bus.mem_writeEn}, 32'd0);
        check("rst_address",   bus.mem_address, 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);

        // CPU read of 0x400
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h400;
        #1;
        check("rd_stall_T", {31'd0, bus.cpu_stall}, 32'd1);
        check("rd_readEn_T", {31'd0, bus.mem_readEn}, 32'd0);
        step();
        check("rd_readEn_T1", {31'd0, bus.mem_readEn}, 32'd1);
        check("rd_addr_T1", bus.mem_address, 32'h400);
        check("rd_stall_T1", {31'd0, bus.cpu_stall}, 32'd1);
        check("rd_ready_T1", {31'd0, bus.cpu_ready}, 32'd0);
        step();
        check("rd_readEn_T2", {31'd0, bus.mem_readEn}, 32'd1);
        check("rd_stall_T2", {31'd0, bus.cpu_stall}, 32'd1);
        step();
        check("rd_ready_T3", {31'd0, bus.cpu_ready}, 32'd1);
        check("rd_rdata_T3", bus.cpu_rdata, 32'hDEAD_BEEF);
        check("rd_err_T3", {31'd0, bus.cpu_err}, 32'd0);
        check("rd_stall_T3", {31'd0, bus.cpu_stall}, 32'd0);
        check("rd_readEn_T3", {31'd0, bus.mem_readEn}, 32'd0);
        bus.cpu_req = 1'b0;
        step();
        check("rd_ready_T4", {31'd0, bus.cpu_ready}, 32'd0);

        // CPU write 0x12345678 to 0x404
        w0 = write_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h404; bus.cpu_wdata = 32'h1234_5678;
        step();
        check("wr_writeEn_T1", {31'd0, bus.mem_writeEn}, 32'd0);
        check("wr_readEn_T1", {31'd0, bus.mem_readEn}, 32'd0);
        step();
        check("wr_writeEn_T2", {31'd0, bus.mem_writeEn}, 32'd1);
        check("wr_dataIn_T2", bus.mem_dataIn, 32'h1234_5678);
        check("wr_addr_T2", bus.mem_address, 32'h404);
        step();
        check("wr_ready_T3", {31'd0, bus.cpu_ready}, 32'd1);
        check("wr_err_T3", {31'd0, bus.cpu_err}, 32'd0);
        check("wr_writeEn_T3", {31'd0, bus.mem_writeEn}, 32'd0);
        check("wr_write_count", write_cnt - w0, 32'd1);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        step();
        // Read back 0x404
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h404;
        step();
        step();
        step();
        check("rb_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("rb_rdata", bus.cpu_rdata, 32'h1234_5678);
        bus.cpu_req = 1'b0;
        step();

        // Misaligned debug read of 0x402
        w0 = write_cnt; r0 = read_cnt;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h402;
        step();
        check("mis_dbg_ready", {31'd0, bus.dbg_ready}, 32'd1);
        check("mis_dbg_err", {31'd0, bus.dbg_err}, 32'd1);
        check("mis_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("mis_readEn", {31'd0, bus.mem_readEn}, 32'd0);
        bus.dbg_req = 1'b0;
        step();
        check("mis_dbg_ready_after", {31'd0, bus.dbg_ready}, 32'd0);
        step();
        check("mis_no_read", read_cnt - r0, 32'd0);
        check("mis_no_write", write_cnt - w0, 32'd0);

        // Tie: both ports request continuously for 4 access slots
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h400;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h404;
        order = 4'b0000; pulses = 0; dbg_pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.cpu_ready || bus.dbg_ready) begin
                if (pulses < 4) order[pulses] = bus.dbg_ready;
                pulses++;
                if (bus.dbg_ready) dbg_pulses++;
            end
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
`ifdef DMEM_ARB_RR_EN
        exp_order = 4'b1010;
        exp_dbg_pulses = 2;
`else
        exp_order = 4'b0000;
        exp_dbg_pulses = 0;
`endif
        check("tie_pulses", pulses, 32'd4);
        check("tie_order", {28'd0, order}, {28'd0, exp_order});
        check("tie_dbg_pulses", dbg_pulses, exp_dbg_pulses);
        step();
        step();

        // Reset during the final cycle of a write
        w0 = write_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h408; bus.cpu_wdata = 32'hA5A5_A5A5;
        step();
        step();
        check("rstw_writeEn_pre", {31'd0, bus.mem_writeEn}, 32'd1);
        rst = 1'b1; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        #1;
        check("rstw_writeEn_gated", {31'd0, bus.mem_writeEn}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rstw_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("rstw_writeEn", {31'd0, bus.mem_writeEn}, 32'd0);
        check("rstw_address", bus.mem_address, 32'd0);
        check("rstw_dataIn", bus.mem_dataIn, 32'd0);
        check("rstw_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rstw_mem", mem[32'h408 >> 2], 32'h1111_1111);
        check("rstw_no_write", write_cnt - w0, 32'd0);
        step();
        check("rstw_no_ready", {31'd0, bus.cpu_ready}, 32'd0);

        // Request dropped mid-access still completes
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h400;
        step();
        bus.cpu_req = 1'b0;
        #1;
        check("drop_readEn_T1", {31'd0, bus.mem_readEn}, 32'd1);
        step();
        check("drop_ready_T2", {31'd0, bus.cpu_ready}, 32'd0);
        step();
        check("drop_ready_T3", {31'd0, bus.cpu_ready}, 32'd1);
        check("drop_rdata_T3", bus.cpu_rdata, 32'hDEAD_BEEF);
        step();
        check("drop_ready_T4", {31'd0, bus.cpu_ready}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the pipeline's data memory. It shares the single memory port between the CPU MEM stage and a debug/DMA port, sequences each access over a fixed number of cycles, and drives a stall to the pipeline while the CPU's access is outstanding. Misaligned requests are rejected without touching memory.

## Interface
- WORD_LEN, 32: data and address width in bits.
- ACCESS_CYCLES, 2: cycles the memory port is held per access, range 1..15.

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- cpu_req  in  1  CPU request; held with its fields until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  WORD_LEN  byte address
- cpu_wdata  in  WORD_LEN  write data
- cpu_rdata  out  WORD_LEN  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  with cpu_ready: request rejected (misaligned)
- cpu_stall  out  1  cpu_req & ~cpu_ready (combinational)
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ready, dbg_err: same as cpu_*, for the debug port
- mem_readEn  out  1  memory read enable
- mem_writeEn  out  1  memory write enable
- mem_address  out  WORD_LEN  memory address
- mem_dataIn  out  WORD_LEN  memory write data
- mem_dataOut  in  WORD_LEN  memory read data (combinational)

## Operation
- States: IDLE, ACCESS, DONE. Reset: state=IDLE, cnt=0, last_grant=DBG, both rdata registers 0; all ready/err/mem enables 0, mem_address/mem_dataIn 0.
- IDLE: if any req is high, pick a winner (see Configuration); latch addr, we and wdata into the operation registers; record grant.
  - If addr[1:0]!=0, go to DONE with err=1. There is no memory access.
  - Otherwise go to ACCESS with cnt=ACCESS_CYCLES-1.
- ACCESS: mem_address and mem_dataIn come from the latched registers.
  - Read: mem_readEn=1 in every ACCESS cycle.
  - Write: mem_writeEn=1 only in the cycle where cnt==0. This gives exactly one write edge per access.
  - cnt decrements each cycle. When cnt==0: for a read, capture mem_dataOut into the granted port's rdata register. Then go to DONE.
- DONE: granted port's ready=1 for exactly one cycle, with err as latched. Update last_grant to the served port. Go to IDLE.
- Only the granted port sees ready or err. The other port's ready=0 and its stall stays high.
- The write response has rdata unchanged from the previous read. Bench must ignore rdata on writes.
- Fields are latched at grant. Changing or dropping req mid-access does not abort the access, and ready is still pulsed.
- Requesters must drop req (or present a new request) in the cycle after ready. A req still high in IDLE is treated as a new request.

## Timing
- Request accepted in cycle T (state IDLE): ACCESS occupies T+1..T+ACCESS_CYCLES, and ready is high in T+ACCESS_CYCLES+1.
- Misaligned request: ready+err in T+1.
- Throughput: one access per ACCESS_CYCLES+2 cycles. IDLE always separates grants.
- Reset mid-operation: mem_writeEn and mem_readEn are gated with ~rst, so no write occurs in a cycle where rst=1. The pending ready is lost, and state is IDLE on the next edge.
- Simultaneous requests in IDLE are resolved in the same cycle. The loser waits at least one full access.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port not in last_grant wins. Reset last_grant=DBG, so the CPU wins the first tie. Neither port can be starved.
- Not defined: fixed priority, the CPU always wins a tie. last_grant is still maintained but unused. The debug port can starve under continuous CPU traffic; this is accepted.

## Test plan
- CPU read: ACCESS_CYCLES=2, mem holds 0xDEADBEEF at 0x400; cpu_req read 0x400 at T -> cpu_ready=1 with rdata=0xDEADBEEF at T+3; mem_readEn high T+1..T+2; cpu_stall high T..T+2.
- CPU write: write 0x12345678 to 0x404 -> mem_writeEn high only at T+2; a following read of 0x404 returns 0x12345678.
- Misaligned: dbg read 0x402 -> dbg_ready=1, dbg_err=1 at T+1; mem_readEn and mem_writeEn never asserted.
- Tie with DMEM_ARB_RR_EN: both ports request continuously for 4 accesses -> grant order CPU, DBG, CPU, DBG. Without the macro -> CPU all 4, dbg_ready never pulses.
- Reset during write: assert rst in the cnt==0 ACCESS cycle -> mem_writeEn=0 that cycle; state IDLE and all outputs 0 on the next cycle; no ready pulse.
- Request dropped mid-access: cpu_req falls at T+1 -> access still completes; cpu_ready pulses at T+3.
